// File: rtl/decode_pipe_unit.sv
// Single-stage instruction decoder with a valid/ready handshake and a load-use interlock.
// Decode outputs are registered; in_ready is combinational from held state and the incoming IR.
module decode_pipe_unit #(
    parameter int unsigned IW        = 64,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned HAZARD_EN = 1,
    parameter int unsigned STRI_EN   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] IR,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          branch,
    output logic          write_to_mem,
    output logic          read_from_mem,
    output logic          write_op_is_reg,
    output logic          write_op_is_imm,
    output logic          write_op_is_regd,
    output logic          br_if_equals,
    output logic          illegal,
    output logic [4:0]    alu_op,
    output logic [5:0]    reg_d,
    output logic [5:0]    reg_a,
    output logic [5:0]    reg_b,
    output logic [63:0]   imm_val
);

    localparam int unsigned OPW = 6;
    localparam int unsigned RW  = 6;
    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 64;
    localparam int unsigned CW  = 3;

    localparam logic [OPW-1:0] OP_NOP  = 6'h00;
    localparam logic [OPW-1:0] OP_MOV  = 6'h01;
    localparam logic [OPW-1:0] OP_LD   = 6'h02;
    localparam logic [OPW-1:0] OP_STR  = 6'h03;
    localparam logic [OPW-1:0] OP_BEQ  = 6'h04;
    localparam logic [OPW-1:0] OP_BNEQ = 6'h05;
    localparam logic [OPW-1:0] OP_ALU  = 6'h06;
    localparam logic [OPW-1:0] OP_LDI  = 6'h07;
    localparam logic [OPW-1:0] OP_STRI = 6'h08;

    logic [OPW-1:0] opcode;
    logic           d_branch, d_wtm, d_rfm, d_wreg, d_wimm, d_wregd, d_beq, d_illegal;
    logic           imm_fmt, use_a, use_b, use_d;
    logic [RW-1:0]  d_reg_d, d_reg_a, d_reg_b;
    logic [AW-1:0]  d_alu_op;
    logic [DW-1:0]  imm_base, d_imm;
    logic [CW-1:0]  ld_cnt;
    logic [RW-1:0]  ld_rd;
    logic           hit_held, hit_ld, stall, accept;

    assign opcode = IR[IW-1 -: OPW];

    // Opcode table: control bits, immediate format and which register fields are sources.
    always_comb begin
        d_branch  = 1'b0;
        d_wtm     = 1'b0;
        d_rfm     = 1'b0;
        d_wreg    = 1'b0;
        d_wimm    = 1'b0;
        d_wregd   = 1'b0;
        d_beq     = 1'b0;
        d_illegal = 1'b0;
        imm_fmt   = 1'b0;
        use_a     = 1'b0;
        use_b     = 1'b0;
        use_d     = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_MOV, OP_ALU: begin
                d_wreg = 1'b1;
                use_a  = 1'b1;
                use_b  = 1'b1;
            end
            OP_LD: begin
                d_rfm = 1'b1;
                use_a = 1'b1;
                use_b = 1'b1;
            end
            OP_STR: begin
                d_wtm  = 1'b1;
                d_wreg = 1'b1;
                use_a  = 1'b1;
                use_b  = 1'b1;
                use_d  = 1'b1;
            end
            OP_BEQ, OP_BNEQ: begin
                d_branch = 1'b1;
                d_wregd  = 1'b1;
                d_beq    = (opcode == OP_BEQ);
                use_a    = 1'b1;
                use_b    = 1'b1;
                use_d    = 1'b1;
            end
            OP_LDI: begin
                d_wimm  = 1'b1;
                imm_fmt = 1'b1;
            end
            OP_STRI: begin
                if (STRI_EN != 0) begin
                    d_wtm   = 1'b1;
                    d_wimm  = 1'b1;
                    imm_fmt = 1'b1;
                    use_d   = 1'b1;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            default: d_illegal = 1'b1;
        endcase
    end

    assign d_reg_d  = imm_fmt ? IR[57:52] : IR[17:12];
    assign d_reg_a  = imm_fmt ? '0 : IR[11:6];
    assign d_reg_b  = imm_fmt ? '0 : IR[5:0];
    assign d_alu_op = imm_fmt ? '0 : IR[22:18];
    assign imm_base = {16'b0, IR[51:4]};
    assign d_imm    = imm_fmt ? (imm_base << {IR[3:0], 2'b00}) : '0;

    // Load-use interlock: held LD still in the output register, or an LD that left recently.
    assign hit_held = (use_a && IR[11:6] == reg_d) || (use_b && IR[5:0] == reg_d) ||
                      (use_d && d_reg_d == reg_d);
    assign hit_ld   = (use_a && IR[11:6] == ld_rd) || (use_b && IR[5:0] == ld_rd) ||
                      (use_d && d_reg_d == ld_rd);
    assign stall    = (HAZARD_EN != 0) &&
                      ((out_valid && read_from_mem && hit_held) || (ld_cnt != '0 && hit_ld));
    assign in_ready = !rst && (!out_valid || out_ready) && !flush && !stall;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            branch           <= 1'b0;
            write_to_mem     <= 1'b0;
            read_from_mem    <= 1'b0;
            write_op_is_reg  <= 1'b0;
            write_op_is_imm  <= 1'b0;
            write_op_is_regd <= 1'b0;
            br_if_equals     <= 1'b0;
            illegal          <= 1'b0;
            alu_op           <= '0;
            reg_d            <= '0;
            reg_a            <= '0;
            reg_b            <= '0;
            imm_val          <= '0;
            ld_cnt           <= '0;
            ld_rd            <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid        <= 1'b1;
                branch           <= d_branch;
                write_to_mem     <= d_wtm;
                read_from_mem    <= d_rfm;
                write_op_is_reg  <= d_wreg;
                write_op_is_imm  <= d_wimm;
                write_op_is_regd <= d_wregd;
                br_if_equals     <= d_beq;
                illegal          <= d_illegal;
                alu_op           <= d_alu_op;
                reg_d            <= d_reg_d;
                reg_a            <= d_reg_a;
                reg_b            <= d_reg_b;
                imm_val          <= d_imm;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Bubble counter armed when a held LD is consumed; flush wins over the hand-off.
            if (flush) begin
                ld_cnt <= '0;
            end else if (out_valid && out_ready && read_from_mem) begin
                ld_cnt <= CW'(LOAD_LAT);
                ld_rd  <= reg_d;
            end else if (ld_cnt != '0) begin
                ld_cnt <= ld_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_decode_pipe_unit.sv
// Bench for decode_pipe_unit: cycle model scoreboard on the main instance plus directed literal checks.
module tb_decode_pipe_unit;

    localparam int unsigned LAT = 2;

    typedef struct packed {
        logic        branch, wtm, rfm, wreg, wimm, wregd, beq, illegal;
        logic [4:0]  alu_op;
        logic [5:0]  rd, ra, rb;
        logic [63:0] imm;
    } obs_t;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] IR;
    logic        branch, write_to_mem, read_from_mem, write_op_is_reg, write_op_is_imm;
    logic        write_op_is_regd, br_if_equals, illegal;
    logic [4:0]  alu_op;
    logic [5:0]  reg_d, reg_a, reg_b;
    logic [63:0] imm_val;

    logic        in_valid2, in_ready2, out_valid2;
    logic [63:0] ir2;
    logic        branch2, write_to_mem2, read_from_mem2, write_op_is_reg2, write_op_is_imm2;
    logic        write_op_is_regd2, br_if_equals2, illegal2;
    logic [4:0]  alu_op2;
    logic [5:0]  reg_d2, reg_a2, reg_b2;
    logic [63:0] imm_val2;

    obs_t act;
    int   errors = 0;
    int   checks = 0;

    decode_pipe_unit #(.IW(64), .LOAD_LAT(LAT), .HAZARD_EN(1), .STRI_EN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .IR(IR),
        .out_valid(out_valid), .out_ready(out_ready), .branch(branch), .write_to_mem(write_to_mem),
        .read_from_mem(read_from_mem), .write_op_is_reg(write_op_is_reg),
        .write_op_is_imm(write_op_is_imm), .write_op_is_regd(write_op_is_regd),
        .br_if_equals(br_if_equals), .illegal(illegal), .alu_op(alu_op), .reg_d(reg_d),
        .reg_a(reg_a), .reg_b(reg_b), .imm_val(imm_val)
    );

    decode_pipe_unit #(.IW(64), .LOAD_LAT(1), .HAZARD_EN(1), .STRI_EN(0)) dut2 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid2), .in_ready(in_ready2), .IR(ir2),
        .out_valid(out_valid2), .out_ready(1'b1), .branch(branch2), .write_to_mem(write_to_mem2),
        .read_from_mem(read_from_mem2), .write_op_is_reg(write_op_is_reg2),
        .write_op_is_imm(write_op_is_imm2), .write_op_is_regd(write_op_is_regd2),
        .br_if_equals(br_if_equals2), .illegal(illegal2), .alu_op(alu_op2), .reg_d(reg_d2),
        .reg_a(reg_a2), .reg_b(reg_b2), .imm_val(imm_val2)
    );

    assign act = {branch, write_to_mem, read_from_mem, write_op_is_reg, write_op_is_imm,
                  write_op_is_regd, br_if_equals, illegal, alu_op, reg_d, reg_a, reg_b, imm_val};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Expected decode written straight from the opcode table; immediate scaled by repeated x16.
    function automatic obs_t model_dec(input logic [63:0] ir);
        obs_t        o;
        logic [63:0] m;
        o = '0;
        case (ir[63:58])
            6'h00: ;
            6'h01: o.wreg = 1'b1;
            6'h02: o.rfm = 1'b1;
            6'h03: begin o.wtm = 1'b1; o.wreg = 1'b1; end
            6'h04: begin o.branch = 1'b1; o.wregd = 1'b1; o.beq = 1'b1; end
            6'h05: begin o.branch = 1'b1; o.wregd = 1'b1; end
            6'h06: o.wreg = 1'b1;
            6'h07: o.wimm = 1'b1;
            6'h08: begin o.wtm = 1'b1; o.wimm = 1'b1; end
            default: o.illegal = 1'b1;
        endcase
        if (ir[63:58] == 6'h07 || ir[63:58] == 6'h08) begin
            o.rd = ir[57:52];
            m = 64'(ir[51:4]);
            for (int i = 0; i < int'(ir[3:0]); i++) m = m * 64'd16;
            o.imm = m;
        end else begin
            o.alu_op = ir[22:18];
            o.rd     = ir[17:12];
            o.ra     = ir[11:6];
            o.rb     = ir[5:0];
        end
        return o;
    endfunction

    function automatic bit model_uses(input logic [63:0] ir, input logic [5:0] r);
        case (ir[63:58])
            6'h01, 6'h02, 6'h06: return (ir[11:6] == r) || (ir[5:0] == r);
            6'h03, 6'h04, 6'h05: return (ir[17:12] == r) || (ir[11:6] == r) || (ir[5:0] == r);
            6'h08: return ir[57:52] == r;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard: a load consumed in cycle k blocks its dependents until cycle k+LAT+1.
    initial begin
        bit   m_valid, stall, exp_ready;
        obs_t m_out;
        int   free_cyc, k;
        logic [5:0] ld_reg;
        m_valid = 1'b0; m_out = '0; free_cyc = 0; k = 0; ld_reg = '0;
        forever begin
            @(negedge clk);
            stall = (m_valid && m_out.rfm && model_uses(IR, m_out.rd)) ||
                    (k < free_cyc && model_uses(IR, ld_reg));
            exp_ready = !rst && (!m_valid || out_ready) && !flush && !stall;
            chk($sformatf("cyc%0d in_ready", k), 128'(in_ready), 128'(exp_ready));
            chk($sformatf("cyc%0d out_valid", k), 128'(out_valid), 128'(m_valid));
            chk($sformatf("cyc%0d outputs", k), 128'(act), 128'(m_out));
            if (rst) begin
                m_valid = 1'b0; m_out = '0; free_cyc = 0; ld_reg = '0;
            end else if (flush) begin
                m_valid = 1'b0; free_cyc = 0;
            end else begin
                if (m_valid && out_ready && m_out.rfm) begin
                    free_cyc = k + int'(LAT) + 1;
                    ld_reg   = m_out.rd;
                end
                if (in_valid && exp_ready) begin
                    m_valid = 1'b1;
                    m_out   = model_dec(IR);
                end else if (out_ready) begin
                    m_valid = 1'b0;
                end
            end
            k++;
        end
    end

    function automatic logic [63:0] mk(input logic [5:0] op, input logic [5:0] d,
                                       input logic [5:0] a, input logic [5:0] b,
                                       input logic [4:0] alu);
        logic [63:0] ir;
        ir = '0;
        ir[63:58] = op; ir[22:18] = alu; ir[17:12] = d; ir[11:6] = a; ir[5:0] = b;
        return ir;
    endfunction

    function automatic logic [63:0] mk_imm(input logic [5:0] op, input logic [5:0] d,
                                           input logic [47:0] imm, input logic [3:0] sh);
        logic [63:0] ir;
        ir = '0;
        ir[63:58] = op; ir[57:52] = d; ir[51:4] = imm; ir[3:0] = sh;
        return ir;
    endfunction

    // Present ir until accepted; returns the number of refused cycles. Entered just after a posedge.
    task automatic send(input logic [63:0] ir, output int waits);
        waits = 0; in_valid = 1'b1; IR = ir;
        @(negedge clk);
        while (!in_ready) begin
            waits++;
            if (waits > 30) begin
                errors++; checks++;
                $display("FAIL send_timeout: got no acceptance expected acceptance within 30 cycles");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; IR = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [63:0] stream [9];
    logic [7:0]  exp_ctl [9] = '{8'b00000000, 8'b00010000, 8'b00100000, 8'b01010000,
                                 8'b10000110, 8'b10000100, 8'b00010000, 8'b00001000,
                                 8'b01001000};

    function automatic logic [7:0] ctl_now();
        return {branch, write_to_mem, read_from_mem, write_op_is_reg, write_op_is_imm,
                write_op_is_regd, br_if_equals, illegal};
    endfunction

    initial begin
        int w;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; IR = '0;
        in_valid2 = 1'b0; ir2 = '0;
        stream[0] = mk(6'h00, 6'd0, 6'd0, 6'd0, 5'd0);
        stream[1] = mk(6'h01, 6'd1, 6'd2, 6'd3, 5'd0);
        stream[2] = mk(6'h02, 6'd10, 6'd2, 6'd3, 5'd0);
        stream[3] = mk(6'h03, 6'd1, 6'd2, 6'd3, 5'd0);
        stream[4] = mk(6'h04, 6'd1, 6'd2, 6'd3, 5'd0);
        stream[5] = mk(6'h05, 6'd1, 6'd2, 6'd3, 5'd0);
        stream[6] = mk(6'h06, 6'd4, 6'd2, 6'd3, 5'd5);
        stream[7] = mk_imm(6'h07, 6'd11, 48'h1234, 4'd2);
        stream[8] = mk_imm(6'h08, 6'd12, 48'h55, 4'd1);

        idle(2);
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_outputs", 128'(act), 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        #1 chk("idle_in_ready", 128'(in_ready), 128'(1));
        idle(1);

        // Every opcode back-to-back with the consumer always ready.
        for (int i = 0; i < 9; i++) begin
            send(stream[i], w);
            chk($sformatf("stream%0d_wait", i), 128'(w), 128'(0));
            chk($sformatf("stream%0d_valid", i), 128'(out_valid), 128'(1));
            chk($sformatf("stream%0d_ctl", i), 128'(ctl_now()), 128'(exp_ctl[i]));
        end
        idle(4);

        send(mk_imm(6'h07, 6'd5, 48'hABCD, 4'd3), w);
        chk("ldi_reg_d", 128'(reg_d), 128'(5));
        chk("ldi_imm", 128'(imm_val), 128'(64'h0000_0000_0ABC_D000));
        chk("ldi_ctl", 128'(ctl_now()), 128'(8'b00001000));
        idle(3);

        // Dependent ALU: refused while the LD is held, then for LAT cycles after it leaves.
        send(mk(6'h02, 6'd7, 6'd0, 6'd0, 5'd0), w);
        send(mk(6'h06, 6'd1, 6'd7, 6'd2, 5'd5), w);
        chk("loaduse_dep_refused", 128'(w), 128'(LAT + 1));
        chk("loaduse_dep_reg_d", 128'(reg_d), 128'(1));
        idle(5);
        send(mk(6'h02, 6'd7, 6'd0, 6'd0, 5'd0), w);
        send(mk(6'h06, 6'd1, 6'd3, 6'd4, 5'd5), w);
        chk("loaduse_indep_refused", 128'(w), 128'(0));
        idle(5);

        out_ready = 1'b0;
        send(mk(6'h01, 6'd6, 6'd2, 6'd3, 5'd0), w);
        in_valid = 1'b1; IR = mk(6'h06, 6'd8, 6'd1, 6'd2, 5'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_in_ready", i), 128'(in_ready), 128'(0));
            chk($sformatf("bp%0d_reg_d", i), 128'(reg_d), 128'(6));
            chk($sformatf("bp%0d_ctl", i), 128'(ctl_now()), 128'(8'b00010000));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; IR = '0;
        chk("bp_next_reg_d", 128'(reg_d), 128'(8));
        idle(3);

        send(mk(6'h3F, 6'd1, 6'd2, 6'd3, 5'd0), w);
        chk("illegal_ctl", 128'(ctl_now()), 128'(8'b00000001));
        send(mk_imm(6'h08, 6'd4, 48'h1, 4'd0), w);
        chk("stri_en_ctl", 128'(ctl_now()), 128'(8'b01001000));
        in_valid2 = 1'b1; ir2 = mk_imm(6'h08, 6'd4, 48'h1, 4'd0);
        @(posedge clk); #1;
        in_valid2 = 1'b0; ir2 = '0;
        chk("stri_dis_valid", 128'(out_valid2), 128'(1));
        chk("stri_dis_ctl", 128'({branch2, write_to_mem2, read_from_mem2, write_op_is_reg2,
                                  write_op_is_imm2, write_op_is_regd2, br_if_equals2, illegal2}),
            128'(8'b00000001));
        idle(3);

        // Flush while a dependent instruction is stalled behind a held LD.
        send(mk(6'h02, 6'd9, 6'd0, 6'd0, 5'd0), w);
        in_valid = 1'b1; IR = mk(6'h06, 6'd5, 6'd9, 6'd0, 5'd1); flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        chk("flush_dep_accept", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; IR = '0;
        chk("flush_dep_reg_d", 128'(reg_d), 128'(5));
        idle(3);

        out_ready = 1'b0;
        send(mk(6'h01, 6'd3, 6'd1, 6'd2, 5'd0), w);
        idle(1);
        rst = 1'b1;
        #1 chk("rst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_outputs", 128'(act), 128'(0));
        rst = 1'b0; out_ready = 1'b1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
